// File: rtl/except_ctrl.sv
// Exception controller: prioritises MEM-stage exceptions and interrupts,
// reports them to CP0, and drives pipeline flush, redirect PC and stalls.
module except_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic        exc_syscall_i,
   input  logic        exc_ri_i,
   input  logic        exc_ov_i,
   input  logic        exc_eret_i,
   input  logic [31:0] inst_addr_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        timer_int_i,
   input  logic        stall_req_id_i,
   input  logic        stall_req_ex_i,
   output logic [31:0] except_o,
   output logic [31:0] cur_inst_addr_o,
   output logic        in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic [5:0]  stall_o
);

   typedef enum logic {
      IDLE,
      FLUSH
   } state_t;

   localparam logic [31:0] CODE_INT  = 32'h0000_0001;
   localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
   localparam logic [31:0] CODE_RI   = 32'h0000_000A;
   localparam logic [31:0] CODE_OV   = 32'h0000_000C;
   localparam logic [31:0] CODE_ERET = 32'h0000_000E;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        timer_pend_q, timer_pend_d;
   logic [31:0] except_q, except_d;
   logic [31:0] addr_q, addr_d;
   logic        ds_q, ds_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;

   logic        timer_pend_v;
   logic [5:0]  int_hit;
   logic        int_req;
   logic        sel_valid;
   logic        sel_int;
   logic        sel_eret;
   logic [31:0] sel_code;

   // Only IP/IM and IE/EXL take part in the interrupt decision.
   logic unused_cp0_bits;
   assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[9:2],
                              cp0_cause_i[31:16], cp0_cause_i[9:0]};

   // Interrupt request; a timer pulse counts as pending in its own cycle.
   always_comb begin
      timer_pend_v = timer_pend_q | timer_int_i;
      int_hit = (cp0_cause_i[15:10] | {timer_pend_v, 5'b0})
                & cp0_status_i[15:10];
      int_req = mem_valid_i & cp0_status_i[0] & ~cp0_status_i[1]
                & (|int_hit);
   end

   // Fixed-priority selection of the exception to report.
   always_comb begin
      sel_valid = 1'b1;
      sel_int   = 1'b0;
      sel_eret  = 1'b0;
      sel_code  = 32'h0;
      if (int_req) begin
         sel_code = CODE_INT;
         sel_int  = 1'b1;
      end else if (mem_valid_i && exc_syscall_i) begin
         sel_code = CODE_SYS;
      end else if (mem_valid_i && exc_ri_i) begin
         sel_code = CODE_RI;
      end else if (mem_valid_i && exc_ov_i) begin
         sel_code = CODE_OV;
      end else if (mem_valid_i && exc_eret_i) begin
         sel_code = CODE_ERET;
         sel_eret = 1'b1;
      end else begin
         sel_valid = 1'b0;
      end
   end

   // Next-state logic for the IDLE/FLUSH machine and its outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      timer_pend_d = timer_pend_v;
      except_d     = 32'h0;
      addr_d       = addr_q;
      ds_d         = ds_q;
      flush_d      = flush_q;
      new_pc_d     = new_pc_q;
      unique case (state_q)
         IDLE: begin
            if (sel_valid) begin
               except_d = sel_code;
               addr_d   = inst_addr_i;
               ds_d     = in_delayslot_i;
               flush_d  = 1'b1;
               new_pc_d = sel_eret ? cp0_epc_i : EXC_VECTOR;
               cnt_d    = FLUSH_LOAD;
               state_d  = FLUSH;
               if (sel_int) begin
                  timer_pend_d = 1'b0;
               end
            end
         end
         FLUSH: begin
            if (cnt_q == 4'd0) begin
               flush_d = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         timer_pend_q <= 1'b0;
         except_q     <= 32'h0;
         addr_q       <= 32'h0;
         ds_q         <= 1'b0;
         flush_q      <= 1'b0;
         new_pc_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timer_pend_q <= timer_pend_d;
         except_q     <= except_d;
         addr_q       <= addr_d;
         ds_q         <= ds_d;
         flush_q      <= flush_d;
         new_pc_q     <= new_pc_d;
      end
   end

   // Stall requests apply only in IDLE; a flush or reset cancels them.
   always_comb begin
      stall_o = 6'b000000;
      if (rst && !flush_q && state_q == IDLE) begin
         if (stall_req_ex_i) begin
            stall_o = 6'b001111;
         end else if (stall_req_id_i) begin
            stall_o = 6'b000111;
         end
      end
   end

   assign except_o        = except_q;
   assign cur_inst_addr_o = addr_q;
   assign in_delayslot_o  = ds_q;
   assign flush_o         = flush_q;
   assign new_pc_o        = new_pc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: stimulus queues expected exceptions and
// flush lengths; a negedge monitor pops and compares them.
module tb_except_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic        exc_syscall_i;
   logic        exc_ri_i;
   logic        exc_ov_i;
   logic        exc_eret_i;
   logic [31:0] inst_addr_i;
   logic        in_delayslot_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        timer_int_i;
   logic        stall_req_id_i;
   logic        stall_req_ex_i;
   logic [31:0] except_o;
   logic [31:0] cur_inst_addr_o;
   logic        in_delayslot_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic [5:0]  stall_o;

   except_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid_i    (mem_valid_i),
      .exc_syscall_i  (exc_syscall_i),
      .exc_ri_i       (exc_ri_i),
      .exc_ov_i       (exc_ov_i),
      .exc_eret_i     (exc_eret_i),
      .inst_addr_i    (inst_addr_i),
      .in_delayslot_i (in_delayslot_i),
      .cp0_status_i   (cp0_status_i),
      .cp0_cause_i    (cp0_cause_i),
      .cp0_epc_i      (cp0_epc_i),
      .timer_int_i    (timer_int_i),
      .stall_req_id_i (stall_req_id_i),
      .stall_req_ex_i (stall_req_ex_i),
      .except_o       (except_o),
      .cur_inst_addr_o(cur_inst_addr_o),
      .in_delayslot_o (in_delayslot_o),
      .flush_o        (flush_o),
      .new_pc_o       (new_pc_o),
      .stall_o        (stall_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] code;
      logic [31:0] addr;
      logic        ds;
      logic [31:0] pc;
   } exc_t;

   exc_t exc_q[$];
   int   flush_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   mon_run = 0;
   exc_t mon_e;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic expect_exc(input logic [31:0] code, input logic [31:0] addr,
                             input logic ds, input logic [31:0] pc);
      exc_q.push_back('{code: code, addr: addr, ds: ds, pc: pc});
      flush_q.push_back(2);
   endtask

   // Monitor: compare every reported exception and every flush run.
   initial begin
      forever begin
         @(negedge clk);
         if (except_o != 32'h0) begin
            if (exc_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_exc: got %h want none", except_o);
            end else begin
               mon_e = exc_q.pop_front();
               chk("exc_code", except_o, mon_e.code);
               chk("exc_addr", cur_inst_addr_o, mon_e.addr);
               chk("exc_ds", {31'b0, in_delayslot_o}, {31'b0, mon_e.ds});
               chk("exc_new_pc", new_pc_o, mon_e.pc);
            end
         end
         if (flush_o) begin
            mon_run++;
         end else if (mon_run > 0) begin
            if (flush_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_flush: got len %0d want none",
                        mon_run);
            end else begin
               chk("flush_len", mon_run, flush_q.pop_front());
            end
            mon_run = 0;
         end
      end
   end

   // Directed stimulus.
   initial begin
      rst            = 1'b0;
      mem_valid_i    = 1'b0;
      exc_syscall_i  = 1'b0;
      exc_ri_i       = 1'b0;
      exc_ov_i       = 1'b0;
      exc_eret_i     = 1'b0;
      inst_addr_i    = 32'h0;
      in_delayslot_i = 1'b0;
      cp0_status_i   = 32'h0;
      cp0_cause_i    = 32'h0;
      cp0_epc_i      = 32'h0;
      timer_int_i    = 1'b0;
      stall_req_id_i = 1'b0;
      stall_req_ex_i = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_except", except_o, 32'h0);
      chk("rst_flush", {31'b0, flush_o}, 32'h0);
      chk("rst_new_pc", new_pc_o, 32'h0);
      chk("rst_addr", cur_inst_addr_o, 32'h0);
      chk("rst_stall", {26'b0, stall_o}, 32'h0);
      stall_req_ex_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // syscall
      mem_valid_i   = 1'b1;
      exc_syscall_i = 1'b1;
      inst_addr_i   = 32'h100;
      expect_exc(32'h8, 32'h100, 1'b0, 32'h20);
      @(negedge clk);
      exc_syscall_i = 1'b0;
      repeat (4) @(negedge clk);

      // interrupt beats overflow; pending timer consumed
      cp0_status_i = 32'h0000_8001;
      timer_int_i  = 1'b1;
      exc_ov_i     = 1'b1;
      inst_addr_i  = 32'h140;
      expect_exc(32'h1, 32'h140, 1'b0, 32'h20);
      @(negedge clk);
      timer_int_i = 1'b0;
      exc_ov_i    = 1'b0;
      repeat (5) @(negedge clk);
      cp0_status_i = 32'h0;
      @(negedge clk);

      // eret, with a syscall held through the whole flush
      cp0_epc_i   = 32'h400;
      exc_eret_i  = 1'b1;
      inst_addr_i = 32'h180;
      expect_exc(32'hE, 32'h180, 1'b0, 32'h400);
      @(negedge clk);
      exc_eret_i    = 1'b0;
      exc_syscall_i = 1'b1;
      repeat (2) @(negedge clk);
      exc_syscall_i = 1'b0;
      chk("new_pc_hold", new_pc_o, 32'h400);
      repeat (3) @(negedge clk);

      // EXL masks the interrupt; syscall still taken
      cp0_status_i = 32'h0000_8003;
      cp0_cause_i  = 32'h0000_8000;
      repeat (3) @(negedge clk);
      inst_addr_i   = 32'h1C0;
      exc_syscall_i = 1'b1;
      expect_exc(32'h8, 32'h1C0, 1'b0, 32'h20);
      @(negedge clk);
      exc_syscall_i = 1'b0;
      repeat (3) @(negedge clk);
      cp0_status_i = 32'h0;
      cp0_cause_i  = 32'h0;
      @(negedge clk);

      // stalls, and flush overriding them
      stall_req_id_i = 1'b1;
      #1 chk("stall_id", {26'b0, stall_o}, 32'h07);
      stall_req_ex_i = 1'b1;
      #1 chk("stall_ex", {26'b0, stall_o}, 32'h0F);
      exc_ri_i       = 1'b1;
      inst_addr_i    = 32'h204;
      in_delayslot_i = 1'b1;
      expect_exc(32'hA, 32'h204, 1'b1, 32'h20);
      @(negedge clk);
      exc_ri_i = 1'b0;
      chk("flush_on", {31'b0, flush_o}, 32'h1);
      chk("stall_flush1", {26'b0, stall_o}, 32'h0);
      @(negedge clk);
      chk("stall_flush2", {26'b0, stall_o}, 32'h0);
      @(negedge clk);
      chk("stall_after", {26'b0, stall_o}, 32'h0F);
      stall_req_id_i = 1'b0;
      stall_req_ex_i = 1'b0;
      in_delayslot_i = 1'b0;
      repeat (2) @(negedge clk);

      // reset in the first flush cycle
      exc_syscall_i = 1'b1;
      inst_addr_i   = 32'h300;
      @(posedge clk);
      #2;
      chk("mid_flush_on", {31'b0, flush_o}, 32'h1);
      chk("mid_except", except_o, 32'h8);
      rst = 1'b0;
      stall_req_ex_i = 1'b1;
      #1;
      chk("mid_rst_flush", {31'b0, flush_o}, 32'h0);
      chk("mid_rst_except", except_o, 32'h0);
      chk("mid_rst_new_pc", new_pc_o, 32'h0);
      chk("mid_rst_addr", cur_inst_addr_o, 32'h0);
      chk("mid_rst_stall", {26'b0, stall_o}, 32'h0);
      @(negedge clk);
      exc_syscall_i  = 1'b0;
      stall_req_ex_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_flush", {31'b0, flush_o}, 32'h0);
      exc_syscall_i = 1'b1;
      inst_addr_i   = 32'h340;
      expect_exc(32'h8, 32'h340, 1'b0, 32'h20);
      @(negedge clk);
      exc_syscall_i = 1'b0;
      repeat (5) @(negedge clk);

      chk("exc_q_drained", exc_q.size(), 32'h0);
      chk("flush_q_drained", flush_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020: handler entry PC for all non-ERET exceptions.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: flush length in cycles, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mem_valid_i, input, 1: MEM stage holds a valid instruction.
REQ-006 SHALL have ports exc_syscall_i, exc_ri_i, exc_ov_i, exc_eret_i, input, 1 each: MEM-stage exception flags.
REQ-007 SHALL have port inst_addr_i, input, 32: MEM-stage instruction address.
REQ-008 SHALL have port in_delayslot_i, input, 1: MEM-stage instruction is in a delay slot.
REQ-009 SHALL have ports cp0_status_i, cp0_cause_i, cp0_epc_i, input, 32 each: current CP0 register values.
REQ-010 SHALL have port timer_int_i, input, 1: CP0 timer-interrupt pulse.
REQ-011 SHALL have ports stall_req_id_i, stall_req_ex_i, input, 1 each: pipeline stall requests.
REQ-012 SHALL have port except_o, output, 32: exception code to CP0.
REQ-013 SHALL have port cur_inst_addr_o, output, 32: faulting address to CP0.
REQ-014 SHALL have port in_delayslot_o, output, 1: delay-slot flag to CP0.
REQ-015 SHALL have port flush_o, output, 1: pipeline flush.
REQ-016 SHALL have port new_pc_o, output, 32: redirect PC, valid while flush_o=1.
REQ-017 SHALL have port stall_o, output, 6: per-stage stall, bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB.

Function
REQ-018 SHALL implement state machine IDLE/FLUSH with a 4-bit flush counter.
REQ-019 SHALL set sticky timer_pend on timer_int_i=1 and clear it only on the edge that issues an interrupt exception.
REQ-020 SHALL compute int_req = mem_valid_i & status[0] & ~status[1] & (((cause[15:10] | {timer_pend,5'b0}) & status[15:10]) != 0).
REQ-021 SHALL, in IDLE, select the exception code with priority int_req=32'h1 > syscall=32'h8 > ri=32'hA > ov=32'hC > eret=32'hE; flags count only when mem_valid_i=1.
REQ-022 SHALL, on a selection edge:
- register except_o=code, cur_inst_addr_o=inst_addr_i, in_delayslot_o=in_delayslot_i;
- set flush_o=1;
- set new_pc_o=cp0_epc_i for ERET, else EXC_VECTOR;
- load counter=FLUSH_CYCLES-1; enter FLUSH.
REQ-023 SHALL return except_o to 0 on the edge after issue, so it is a one-cycle pulse.
REQ-024 SHALL, in FLUSH, decrement the counter each edge; at counter=0, clear flush_o and enter IDLE, so flush_o is high exactly FLUSH_CYCLES cycles.
REQ-025 SHALL ignore all exception flags in FLUSH, including on the exit edge; timer_pend still sets.
REQ-026 SHALL drive stall_o combinationally in IDLE:
- stall_req_ex_i=1 -> 6'b001111;
- else stall_req_id_i=1 -> 6'b000111;
- else 0.
REQ-027 SHALL force stall_o=0 whenever flush_o=1; flush overrides stall requests.
REQ-028 SHALL leave new_pc_o unchanged outside issue edges.

Reset
REQ-029 SHALL, on rst=0 at any time including mid-FLUSH, immediately set:
- state=IDLE, counter=0, timer_pend=0;
- except_o=0, cur_inst_addr_o=0, in_delayslot_o=0;
- flush_o=0, new_pc_o=0.
REQ-030 SHALL hold stall_o=0 while rst=0.

Verification
REQ-031 SHALL test syscall: mem_valid=1, syscall=1, addr=0x100, delayslot=0 -> except_o=0x8 one cycle; flush_o=1 for 2 cycles; new_pc_o=0x20.
REQ-032 SHALL test priority: status=0x0000_8001 + timer_int pulse + ov=1 same cycle -> except_o=0x1; timer_pend cleared; ov dropped.
REQ-033 SHALL test ERET: epc=0x0000_0400, eret=1 -> except_o=0xE, new_pc_o=0x400; a second syscall during FLUSH -> no new except_o.
REQ-034 SHALL test masking: status[1]=1 (EXL) with cause[15:10]=6'h20, status[15:10]=6'h20 -> no interrupt; syscall then -> 0x8.
REQ-035 SHALL test stalls: stall_req_id=1 -> 6'b000111; plus stall_req_ex=1 -> 6'b001111; plus ri exception -> stall_o=0 while flush_o=1.
REQ-036 SHALL test reset mid-flush: rst=0 in the first FLUSH cycle -> flush_o=0 immediately; IDLE after release.
